// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmit and receive stages.
//   state_t       - FSM state codes, also driven onto the debug 'state' ports
//   DEFAULT_WIDTH - default number of data bits per frame
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/deser_hold_reg.sv
// deser_hold_reg: single-entry valid/ready holding register for assembled words.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - a word completed this cycle
//   load_data   - the completed word
//   ready       - consumer accepts 'data' when 'valid' is high
//   data, valid - the held word and its valid flag
//   ovf         - sticky: a completed word arrived while the entry was full and not draining
module deser_hold_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;
  logic             ovf_reg;
  logic             accept;
  logic             drop;

  // A word can be taken when the entry is empty or is being drained on this
  // same edge; otherwise it is lost and the overflow flag latches.
  assign accept = load && (!valid_reg || ready);
  assign drop   = load && valid_reg && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (accept) begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end else if (valid_reg && ready) begin
        valid_reg <= 1'b0;
      end
      if (drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: receives MSB-first serial frames strobed by svalid and
// rebuilds WIDTH-bit words, optionally followed by an even-parity bit.
// Ports:
//   s_clk, rst_n          - clock, asynchronous active-low reset
//   sdata, svalid         - serial bit and frame strobe (high for every bit of a frame)
//   out_data, out_valid   - assembled word and its valid flag
//   out_ready             - consumer handshake
//   frame_err, parity_err - one-cycle error pulses
//   ovf                   - sticky word-dropped flag
//   state                 - FSM state code for debug
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             s_clk,
  input  logic             rst_n,
  input  logic             sdata,
  input  logic             svalid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             ovf,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             frame_err_reg;
  logic             parity_err_reg;

  logic             last_data;
  logic             parity_ok;
  logic             word_done;
  logic [WIDTH-1:0] word_data;

  // Completion is decoded combinationally so the holding register loads on the
  // same edge that samples the final bit.
  always_comb begin
    last_data = (count_reg == CW'(WIDTH - 1));
    parity_ok = ~(^shift_reg ^ sdata);
    word_done = 1'b0;
    word_data = shift_reg;
    case (state_reg)
      SHIFT: begin
        if (svalid && last_data && (PARITY_EN == 1'b0)) begin
          word_done = 1'b1;
          word_data = {shift_reg[WIDTH-2:0], sdata};
        end
      end
      PARITY: begin
        if (svalid && parity_ok) begin
          word_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      shift_reg      <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      case (state_reg)
        SHIFT: begin
          if (svalid) begin
            shift_reg <= {shift_reg[WIDTH-2:0], sdata};
            if (last_data) begin
              count_reg <= '0;
              state_reg <= PARITY_EN ? PARITY : IDLE;
            end else begin
              count_reg <= count_reg + CW'(1);
            end
          end else begin
            frame_err_reg <= 1'b1;
            count_reg     <= '0;
            state_reg     <= IDLE;
          end
        end
        PARITY: begin
          if (svalid) begin
            parity_err_reg <= ~parity_ok;
          end else begin
            frame_err_reg <= 1'b1;
          end
          count_reg <= '0;
          state_reg <= IDLE;
        end
        default: begin
          // IDLE, and the unused code 2'b11, start a frame on the first strobed bit.
          if (svalid) begin
            shift_reg <= {{(WIDTH-1){1'b0}}, sdata};
            count_reg <= CW'(1);
            state_reg <= SHIFT;
          end
        end
      endcase
    end
  end

  deser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (s_clk),
    .rst_n    (rst_n),
    .load     (word_done),
    .load_data(word_data),
    .ready    (out_ready),
    .data     (out_data),
    .valid    (out_valid),
    .ovf      (ovf)
  );

  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign state      = state_reg;

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Downstream receive stage of the parallel-to-serial path: samples the one-bit serial stream, framed by a valid strobe, on s_clk.
- Reassembles each frame into a WIDTH-bit parallel word, MSB first, with optional even-parity check.
- Presents each word on a valid/ready output port backed by a single holding register.
- Reports framing, parity and overflow errors; exposes its FSM state for debug, like the transmit stage.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- PARITY_EN, 0, 1 = one even-parity bit follows the data bits in each frame.

Ports:
- s_clk  input  1  serial-domain clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sdata  input  1  serial data bit, MSB first.
- svalid  input  1  frame strobe; high for every bit cycle of a frame.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high at a clock edge.
- frame_err  output  1  one-cycle pulse: frame ended early.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- ovf  output  1  sticky: a completed word was dropped.
- state  output  2  FSM state code.

Behaviour:
- One clock (s_clk); reset is asynchronous and active-low (rst_n).
- Reset (any time, including mid-frame) forces:
  - state=IDLE, bit counter 0, shift register 0;
  - out_data=0, out_valid=0, frame_err=0, parity_err=0, ovf=0.
- States: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10 (only reachable when PARITY_EN=1); 2'b11 unused and decodes to IDLE.
- Sampling: exactly one bit per edge at which svalid=1; no gap cycles within a frame.
- IDLE:
  - svalid=1 → sample bit WIDTH-1, count=1, go to SHIFT.
  - WIDTH=1 is not supported.
- SHIFT, svalid=1:
  - shift sdata into the LSB and increment count.
  - On the edge sampling the last data bit (count reaches WIDTH):
    - PARITY_EN=0 → word complete, go to IDLE.
    - PARITY_EN=1 → go to PARITY.
- PARITY, svalid=1:
  - sample the parity bit.
  - XOR of the data bits and the parity bit must be 0.
  - Match → word complete. Mismatch → parity_err=1 for one cycle, word discarded.
  - Go to IDLE either way.
- svalid=0 in SHIFT or PARITY:
  - frame_err=1 for one cycle, partial word discarded, go to IDLE.
  - No word is produced.
- Back-to-back frames:
  - svalid held high continuously; the edge after a frame's last bit is the first bit of the next frame.
  - An IDLE state lasting zero cycles is legal (IDLE is transited on that edge).
- Word complete at edge E:
  - if out_valid=0, or out_valid=1 and out_ready=1 at E → load out_data and set out_valid=1 after E.
  - Latency: out_valid rises the edge the last bit (or parity bit) is sampled; the word is visible in the following cycle.
  - if out_valid=1 and out_ready=0 at E → new word dropped, out_data unchanged, ovf=1 (sticky until rst_n).
- Pop: out_valid=1 and out_ready=1 at an edge with no completion → out_valid=0 after that edge.
- Simultaneous pop and completion: pop and load occur together; out_valid stays 1.
- out_data is stable while out_valid=1 and out_ready=0.
- Errors are reported only after their frame; they never affect the holding register.

Decomposition:
- Shared package serial_pkg holds:
  - state enum (IDLE/SHIFT/PARITY) with explicit 2-bit encodings, shared with the transmit stage's state output;
  - default WIDTH constant.
- One sub-module is natural: deser_hold_reg, the single-entry valid/ready holding register with the overflow flag.
- FSM, counter, shift register and parity logic stay in the top module.

Test Plan:
- Reset mid-frame: assert rst_n=0 after 3 bits of a frame → all outputs 0 and state=2'b00 immediately (asynchronous); next full frame is received correctly.
- WIDTH=8, PARITY_EN=0, out_ready=1: svalid high 8 cycles, bits 1,0,1,0,0,1,0,1 → out_valid high one cycle with out_data=8'hA5; state sequence 00,01…01,00.
- Back-to-back: 16 continuous svalid cycles carrying 8'h3C then 8'hC3, out_ready=1 → two out_valid pulses 8 cycles apart with correct data; no errors.
- Backpressure: out_ready=0, send 8'h11 then 8'h22 → out_data stays 8'h11, ovf=1 and stays 1; raise out_ready → 8'h11 consumed, out_valid=0.
- Short frame: svalid drops after 5 bits → frame_err pulses one cycle, out_valid stays 0, state returns to 00; the following frame 8'hFF is received correctly.
- PARITY_EN=1: 8'h07 with parity bit 1 → accepted. 8'h07 with parity bit 0 → parity_err pulse, out_valid stays 0.
